pdm_decimator: RTL
==================

// Module: pdm_decimator
// PURPOSE
//  Receive-side counterpart of the synth's 1-bit PDM DAC. Turns a PDM bitstream back into
//  signed PCM samples using a STAGES-order CIC decimator (pipelined integrators, combs).
//  Used for on-chip loopback self-test of the audio path, and to capture PDM from an
//  external source at the decimated sample rate.
// PARAMETERS
//  DECIM        64  decimation ratio, in enabled input bits per output sample; power of 2, >=4
//  STAGES       3   CIC order, i.e. the number of integrator stages and of comb stages (1..4)
//  OUTPUT_BITS  12  width of the signed PCM output word
// PORTS
//  clk        in   1            system clock; all state on posedge
//  rst_n      in   1            async active-low reset
//  pdm_in     in   1            PDM bit; 1 => +1, 0 => -1; synchronous to clk (no synchronizer)
//  pdm_en     in   1            input-bit qualifier; state advances only when high
//  pcm_out    out  OUTPUT_BITS  signed PCM sample; held between updates
//  pcm_valid  out  1            one-cycle pulse, asserted with each new pcm_out
// BEHAVIOUR
//  - Reset: async, while rst_n=0. Clears all integrators, comb delays and the decim counter;
//    pcm_out=0, pcm_valid=0. Releases on the first posedge with rst_n=1. Reset mid-frame
//    discards the partial frame.
//  - Internal width W = STAGES*log2(DECIM)+2, signed two's complement. Integrator and comb
//    arithmetic wraps modulo 2^W by design; no saturation inside the CIC.
//  - x = pdm_in ? +1 : -1, sign-extended to W.
//  - Integrators, on a cycle with pdm_en=1: i1<=i1+x; ik<=ik+i(k-1) for k=2..STAGES.
//    Each stage uses the registered value of the stage before it. pdm_en=0 holds all state.
//  - cnt counts enabled bits 0..DECIM-1. tick = pdm_en & (cnt==DECIM-1). On tick, cnt wraps to 0.
//  - Combs (combinational, evaluated on tick): c0=i_STAGES (register value, pre-update);
//    ck=c(k-1)-dk. On tick: dk<=c(k-1) for each k.
//  - Output: on tick, pcm_out <= sat(c_STAGES >>> (W-1-OUTPUT_BITS)), an arithmetic shift,
//    saturated to [-2^(OUTPUT_BITS-1), 2^(OUTPUT_BITS-1)-1]. pcm_valid<=1 for exactly that one
//    cycle; 0 otherwise. Latency: new pcm_out and pcm_valid are visible the cycle after tick.
//  - Scaling: full-scale +DECIM^STAGES maps to +2^(OUTPUT_BITS-1), which saturates to 2047.
//    -full-scale maps to -2048. Net effect is the inverse of the DAC's offset-binary density
//    mapping.
//  - Transient: comb delays start at 0 after reset, so the first STAGES outputs are not
//    meaningful. From the (STAGES+2)-th pcm_valid onward, a constant input density gives a
//    constant output.
//  - pdm_en low on a tick candidate cycle: no tick. The tick occurs on the next cycle with
//    pdm_en high.
//  - Output rate: exactly one pcm_valid per DECIM enabled bits; the clock-cycle spacing is
//    not fixed.
//  - Elaboration: fails (error) if DECIM is not a power of 2 or STAGES is outside 1..4.
// TESTING
//  1. pdm_in=1, pdm_en=1 constant -> pcm_valid every 64 clk; from the 5th pulse on,
//     pcm_out=2047 (saturated).
//  2. pdm_in=0 constant -> from the 5th pulse on, pcm_out=-2048. No wrap artefacts over
//     1000 frames.
//  3. pdm_in alternating 1,0 -> from the 5th pulse on, pcm_out=0 exactly.
//  4. Loopback: dac din=512 -> pdm_in -> from the 5th pulse on, pcm_out within 512+/-2;
//     repeat with din=-1000 -> within -1000+/-2.
//  5. pdm_en high every other clk, pdm_in=1 -> pcm_valid every 128 clk, same values as test 1.
//     pdm_in toggled only while pdm_en=0 -> no effect on pcm_out.
//  6. rst_n pulsed low mid-frame (cnt=30) -> pcm_out=0 and pcm_valid=0 with no clock edge.
//     First pcm_valid follows exactly 64 enabled bits after release, plus one cycle.

Source files
------------

// File: rtl/pdm_decimator.sv
`default_nettype none
// ============================================================================
// Module      : pdm_decimator
// Description : STAGES-order CIC decimator turning a 1-bit PDM stream into
//               saturated signed PCM samples at 1/DECIM of the enabled bit rate.
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_decimator #(
    parameter int DECIM       = 64,
    parameter int STAGES      = 3,
    parameter int OUTPUT_BITS = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pdm_in,
    input  logic                   pdm_en,
    output logic [OUTPUT_BITS-1:0] pcm_out,
    output logic                   pcm_valid
);

    localparam int c_LOG2_DECIM = $clog2(DECIM);
    localparam int c_W          = STAGES * c_LOG2_DECIM + 2;
    localparam int c_SHIFT      = c_W - 1 - OUTPUT_BITS;
    localparam int c_CNT_W      = (c_LOG2_DECIM < 1) ? 1 : c_LOG2_DECIM;

    localparam logic [c_CNT_W-1:0]    c_CNT_MAX = c_CNT_W'(DECIM - 1);
    localparam logic signed [c_W-1:0] c_PCM_MAX = c_W'((1 << (OUTPUT_BITS - 1)) - 1);
    localparam logic signed [c_W-1:0] c_PCM_MIN = ~c_PCM_MAX;

    generate
        if ((DECIM < 4) || ((DECIM & (DECIM - 1)) != 0)) begin : g_bad_decim
            $error("pdm_decimator: DECIM must be a power of 2 and >= 4");
        end
        if ((STAGES < 1) || (STAGES > 4)) begin : g_bad_stages
            $error("pdm_decimator: STAGES must be in 1..4");
        end
    endgenerate

    logic signed [c_W-1:0]     r_integ [STAGES];
    logic signed [c_W-1:0]     r_dly   [STAGES];
    logic [c_CNT_W-1:0]        r_cnt;

    logic signed [c_W-1:0]     w_x;
    logic                      w_tick;
    logic signed [c_W-1:0]     w_comb_in [STAGES];
    logic signed [c_W-1:0]     w_comb_out;
    logic signed [c_W-1:0]     w_shifted;
    logic [OUTPUT_BITS-1:0]    w_sat;

    assign w_x    = pdm_in ? c_W'(1) : {c_W{1'b1}};
    assign w_tick = pdm_en && (r_cnt == c_CNT_MAX);

    // Comb chain fed by the last integrator's registered (pre-update) value.
    always_comb begin
        logic signed [c_W-1:0] v_acc;
        v_acc = r_integ[STAGES-1];
        for (int k = 0; k < STAGES; k++) begin
            w_comb_in[k] = v_acc;
            v_acc        = v_acc - r_dly[k];
        end
        w_comb_out = v_acc;
    end

    generate
        if (c_SHIFT >= 0) begin : g_shift_right
            assign w_shifted = w_comb_out >>> c_SHIFT;
        end else begin : g_shift_left
            assign w_shifted = w_comb_out <<< (-c_SHIFT);
        end
    endgenerate

    always_comb begin
        w_sat = w_shifted[OUTPUT_BITS-1:0];
        if (w_shifted > c_PCM_MAX) begin
            w_sat = c_PCM_MAX[OUTPUT_BITS-1:0];
        end else if (w_shifted < c_PCM_MIN) begin
            w_sat = c_PCM_MIN[OUTPUT_BITS-1:0];
        end
    end

    // Integrator and comb arithmetic wraps modulo 2^c_W; the comb differences recover the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_integ[k] <= '0;
                r_dly[k]   <= '0;
            end
            r_cnt     <= '0;
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
        end else begin
            pcm_valid <= 1'b0;
            if (pdm_en) begin
                r_integ[0] <= r_integ[0] + w_x;
                for (int k = 1; k < STAGES; k++) begin
                    r_integ[k] <= r_integ[k] + r_integ[k-1];
                end
                if (w_tick) begin
                    r_cnt <= '0;
                    for (int k = 0; k < STAGES; k++) begin
                        r_dly[k] <= w_comb_in[k];
                    end
                    pcm_out   <= w_sat;
                    pcm_valid <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire
